wrr_burst_arbiter: RTL and testbench

- Weighted round-robin arbiter that shares one burst-capable resource between N requesters.
- Each grant is held for up to a per-requester number of beats, set by the weight for that requester.
- A grant ends early if the owner drops its request, or if the resource stalls past a watchdog limit.
- Sits between the requester front-ends and the shared resource. It replaces single-cycle round-robin granting where bursts must not be broken up.

---
 rtl/wrr_burst_arbiter.sv | 175 +++++++++++++++++
 tb/tb_wrr_burst_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter that holds each grant for a weighted burst of beats.
// A grant is released when the burst completes, the owner drops its request, or the watchdog expires.
module wrr_burst_arbiter #(
    parameter int N       = 4,
    parameter int WW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WW-1:0]      wt,
    input  logic                 beat,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic [WW-1:0]        beats_left,
    output logic                 timeout
);

    localparam int OW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [N-1:0]  gnt_r, gnt_nxt_s;
    logic [OW-1:0] owner_r, owner_nxt_s;
    logic [WW-1:0] bl_r, bl_nxt_s;
    logic [TW-1:0] wd_r, wd_nxt_s;
    logic [OW-1:0] ptr_r, ptr_nxt_s;
    logic          to_r, to_nxt_s;

    logic          busy_s, own_req_s, drop_s, done_s, wdog_s, rel_s;
    logic [OW:0]   owner_inc_s;
    logic [OW-1:0] ptr_after_s, arb_ptr_s;
    logic [N-1:0]  req_m_s;
    logic [OW:0]   sum_s, idx_s;
    logic          found_s;
    logic [OW-1:0] win_s;
    logic [WW-1:0] wt_win_s, w_eff_s;

    // Release conditions, in priority order, and the inputs to the next arbitration.
    always_comb begin
        busy_s      = (state_r == BUSY);
        own_req_s   = req[owner_r];
        drop_s      = busy_s & ~own_req_s;
        done_s      = busy_s & own_req_s & beat & (bl_r == WW'(1));
        wdog_s      = busy_s & own_req_s & ~beat & (wd_r == TW'(TIMEOUT - 1));
        rel_s       = drop_s | done_s | wdog_s;
        owner_inc_s = {1'b0, owner_r} + (OW+1)'(1);
        if (owner_inc_s == (OW+1)'(N)) begin
            ptr_after_s = '0;
        end else begin
            ptr_after_s = owner_inc_s[OW-1:0];
        end
        if (rel_s) begin
            arb_ptr_s = ptr_after_s;
        end else begin
            arb_ptr_s = ptr_r;
        end
        // The releasing owner must see one idle cycle before it can win again.
        if (busy_s) begin
            req_m_s = req & ~gnt_r;
        end else begin
            req_m_s = req;
        end
    end

    // Rotating priority scan starting at arb_ptr_s, wrapping modulo N.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        sum_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, arb_ptr_s} + (OW+1)'(k);
            if (sum_s >= (OW+1)'(N)) begin
                idx_s = sum_s - (OW+1)'(N);
            end else begin
                idx_s = sum_s;
            end
            if (!found_s && req_m_s[idx_s[OW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[OW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        wt_win_s = wt[win_s*WW +: WW];
        w_eff_s  = (wt_win_s == '0) ? WW'(1) : wt_win_s;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        owner_nxt_s = owner_r;
        bl_nxt_s    = bl_r;
        wd_nxt_s    = wd_r;
        ptr_nxt_s   = ptr_r;
        to_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt_s = BUSY;
                    gnt_nxt_s   = N'(1) << win_s;
                    owner_nxt_s = win_s;
                    bl_nxt_s    = w_eff_s;
                    wd_nxt_s    = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (rel_s) begin
                    ptr_nxt_s = ptr_after_s;
                    to_nxt_s  = wdog_s;
                    wd_nxt_s  = '0;
                    if (found_s) begin
                        gnt_nxt_s   = N'(1) << win_s;
                        owner_nxt_s = win_s;
                        bl_nxt_s    = w_eff_s;
                    end else begin
                        state_nxt_s = IDLE;
                        gnt_nxt_s   = '0;
                        owner_nxt_s = '0;
                        bl_nxt_s    = '0;
                    end
                end else if (beat) begin
                    bl_nxt_s = bl_r - WW'(1);
                    wd_nxt_s = '0;
                end else begin
                    wd_nxt_s = wd_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = '0;
                owner_nxt_s = '0;
                bl_nxt_s    = '0;
                wd_nxt_s    = '0;
                ptr_nxt_s   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            owner_r <= '0;
            bl_r    <= '0;
            wd_r    <= '0;
            ptr_r   <= '0;
            to_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            owner_r <= owner_nxt_s;
            bl_r    <= bl_nxt_s;
            wd_r    <= wd_nxt_s;
            ptr_r   <= ptr_nxt_s;
            to_r    <= to_nxt_s;
        end
    end

    assign gnt        = gnt_r;
    assign owner      = owner_r;
    assign beats_left = bl_r;
    assign timeout    = to_r;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed self-checking bench for wrr_burst_arbiter with hand-computed expectations.
module tb_wrr_burst_arbiter;

    localparam int N       = 4;
    localparam int WW      = 4;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*WW-1:0] wt;
    logic            beat;
    logic [N-1:0]    gnt;
    logic [1:0]      owner;
    logic [WW-1:0]   beats_left;
    logic            timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wrr_burst_arbiter #(.N(N), .WW(WW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .wt(wt), .beat(beat),
        .gnt(gnt), .owner(owner), .beats_left(beats_left), .timeout(timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        beat = 1'b0;
        tick();
        rst  = 1'b0;
    endtask

    logic [3:0] g1 [9]  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                            4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0] b1 [9]  = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    logic [3:0] g2 [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                            4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] b2 [10] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd1, 4'd3, 4'd2, 4'd1, 4'd1, 4'd4};

    initial begin
        rst  = 1'b1;
        req  = '0;
        wt   = '0;
        beat = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_owner", 32'(owner), 32'd0);
        check_eq("rst_bl", 32'(beats_left), 32'd0);
        check_eq("rst_to", 32'(timeout), 32'd0);

        // Equal weights of 2, all requesting, beat every cycle
        wt   = 16'h2222;
        req  = 4'b1111;
        beat = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq($sformatf("t1_gnt%0d", i), 32'(gnt), 32'(g1[i]));
            check_eq($sformatf("t1_bl%0d", i), 32'(beats_left), 32'(b1[i]));
        end

        // Mixed weights {1,3,0,4}: lengths 4,1,3,1
        do_reset();
        wt   = 16'h1304;
        req  = 4'b1111;
        beat = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(g2[i]));
            check_eq($sformatf("t2_bl%0d", i), 32'(beats_left), 32'(b2[i]));
        end

        // Owner drops its request mid-burst
        do_reset();
        wt   = 16'h0204;
        req  = 4'b0101;
        beat = 1'b0;
        tick();
        check_eq("t3_gnt0", 32'(gnt), 32'b0001);
        check_eq("t3_bl0", 32'(beats_left), 32'd4);
        beat = 1'b1;
        tick();
        check_eq("t3_bl1", 32'(beats_left), 32'd3);
        req = 4'b0100;
        tick();
        check_eq("t3_gnt_drop", 32'(gnt), 32'b0100);
        check_eq("t3_owner_drop", 32'(owner), 32'd2);
        check_eq("t3_bl_drop", 32'(beats_left), 32'd2);
        tick();
        check_eq("t3_bl_next", 32'(beats_left), 32'd1);

        // Watchdog release with a stalled resource
        do_reset();
        wt   = 16'h0000;
        req  = 4'b0010;
        beat = 1'b0;
        tick();
        check_eq("t4_gnt_first", 32'(gnt), 32'b0010);
        check_eq("t4_bl_w0", 32'(beats_left), 32'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            check_eq($sformatf("t4_hold%0d", i), 32'({gnt, timeout}), 32'({4'b0010, 1'b0}));
        end
        tick();
        check_eq("t4_rel_gnt", 32'(gnt), 32'd0);
        check_eq("t4_rel_to", 32'(timeout), 32'd1);
        tick();
        check_eq("t4_regnt", 32'(gnt), 32'b0010);
        check_eq("t4_to_clr", 32'(timeout), 32'd0);

        // Reset mid-burst restarts the pointer at 0
        do_reset();
        wt   = 16'h0100;
        req  = 4'b0100;
        beat = 1'b1;
        tick();
        check_eq("t5_gnt_a", 32'(gnt), 32'b0100);
        tick();
        check_eq("t5_rel", 32'(gnt), 32'd0);
        wt   = 16'h0300;
        beat = 1'b0;
        tick();
        check_eq("t5_gnt_b", 32'(gnt), 32'b0100);
        check_eq("t5_bl_b", 32'(beats_left), 32'd3);
        rst = 1'b1;
        req = 4'b1100;
        tick();
        check_eq("t5_rst_out", 32'({gnt, owner, beats_left, timeout}), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("t5_gnt_after", 32'(gnt), 32'b0100);
        check_eq("t5_owner_after", 32'(owner), 32'd2);

        // Single requester, then idle with beat pulses
        do_reset();
        wt  = 16'h2000;
        req = 4'b1000;
        tick();
        check_eq("t6_gnt", 32'(gnt), 32'b1000);
        check_eq("t6_owner", 32'(owner), 32'd3);
        req = 4'b0000;
        tick();
        check_eq("t6_rel", 32'({gnt, owner}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat = ~beat;
            tick();
            check_eq($sformatf("t6_idle%0d", i), 32'({gnt, beats_left, timeout}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
